// File: rtl/avalon_width_adapter.sv
// Avalon-MM width adapter: a wide slave command is split into RATIO narrow master beats,
// low slice first. Write beats with no enabled bytes are skipped. Pipelined reads are
// tracked (up to MAX_PEND) and their narrow responses reassembled into full slave words.
module avalon_width_adapter #(
    parameter int ADDR_W   = 26,
    parameter int SLV_DW   = 32,
    parameter int MST_DW   = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ADDR_W-1:0]                slave_address,
    input  logic                             slave_read,
    input  logic                             slave_write,
    input  logic [SLV_DW-1:0]                slave_writedata,
    input  logic [SLV_DW/8-1:0]              slave_byteenable,
    output logic                             slave_waitrequest,
    output logic [SLV_DW-1:0]                slave_readdata,
    output logic                             slave_readdatavalid,
    output logic [ADDR_W-1:0]                master_address,
    output logic                             master_read,
    output logic                             master_write,
    output logic [MST_DW-1:0]                master_writedata,
    output logic [MST_DW/8-1:0]              master_byteenable,
    input  logic                             master_waitrequest,
    input  logic [MST_DW-1:0]                master_readdata,
    input  logic                             master_readdatavalid,
    output logic [$clog2(MAX_PEND+1)-1:0]    pend_count,
    output logic                             err_unexpected
);

    localparam int RATIO  = SLV_DW / MST_DW;
    localparam int STEP   = MST_DW / 8;
    localparam int SBE_W  = SLV_DW / 8;
    localparam int MBE_W  = MST_DW / 8;
    localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RATIO - 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    beat;
    logic                op_read;
    logic [ADDR_W-1:0]   cmd_address;
    logic [SLV_DW-1:0]   cmd_data;
    logic [SBE_W-1:0]    cmd_be;

    logic [MST_DW-1:0]   data_slice;
    logic [MBE_W-1:0]    be_slice;
    logic                accept;
    logic                read_accept;
    logic                beat_done;

    logic [IDX_W-1:0]    rx;
    logic [SLV_DW-1:0]   hold;
    logic [SLV_DW-1:0]   assembled;

    // Select the current beat's data and byte-enable slice from the latched command
    always_comb begin
        data_slice = cmd_data[int'(beat) * MST_DW +: MST_DW];
        be_slice   = cmd_be[int'(beat) * MBE_W +: MBE_W];
    end

    // Slave handshake and beat progress; zero-enable write beats advance without a strobe
    always_comb begin
        slave_waitrequest = (state == ISSUE) ||
                            (slave_read && (pend_count == PEND_W'(MAX_PEND)));
        accept      = (state == IDLE) && (slave_read || slave_write) && !slave_waitrequest;
        read_accept = accept && slave_read;
        beat_done   = (state == ISSUE) &&
                      (!master_waitrequest || (!op_read && (be_slice == '0)));
    end

    // Master outputs are driven from latched command state only, so they hold under waitrequest
    always_comb begin
        master_read       = 1'b0;
        master_write      = 1'b0;
        master_address    = cmd_address + ADDR_W'(int'(beat) * STEP);
        master_writedata  = data_slice;
        master_byteenable = '1;
        if (!op_read) begin
            master_byteenable = be_slice;
        end
        if (state == ISSUE) begin
            master_read  = op_read;
            master_write = !op_read && (be_slice != '0);
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: IDLE waits for a command, ISSUE runs until the last beat advances
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (beat_done && (beat == LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command capture on accept and beat index progression
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat        <= '0;
            op_read     <= 1'b0;
            cmd_address <= '0;
            cmd_data    <= '0;
            cmd_be      <= '0;
        end else if (accept) begin
            beat        <= '0;
            op_read     <= slave_read;
            cmd_address <= slave_address;
            cmd_data    <= slave_writedata;
            cmd_be      <= slave_byteenable;
        end else if (beat_done) begin
            beat <= (beat == LAST) ? '0 : beat + 1'b1;
        end
    end

    // Outstanding slave read count: up on read accept, down on each completed slave response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_count <= '0;
        end else begin
            case ({read_accept, slave_readdatavalid})
                2'b10:   pend_count <= pend_count + PEND_W'(1);
                2'b01:   pend_count <= pend_count - PEND_W'(1);
                default: pend_count <= pend_count;
            endcase
        end
    end

    // Holding register with the incoming beat merged into slice rx
    always_comb begin
        assembled = hold;
        assembled[int'(rx) * MST_DW +: MST_DW] = master_readdata;
    end

    // Read reassembly; responses with nothing outstanding are dropped and flagged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx                  <= '0;
            hold                <= '0;
            slave_readdata      <= '0;
            slave_readdatavalid <= 1'b0;
            err_unexpected      <= 1'b0;
        end else begin
            slave_readdatavalid <= 1'b0;
            if (master_readdatavalid) begin
                if (pend_count == '0) begin
                    err_unexpected <= 1'b1;
                end else begin
                    hold <= assembled;
                    if (rx == LAST) begin
                        slave_readdata      <= assembled;
                        slave_readdatavalid <= 1'b1;
                        rx                  <= '0;
                    end else begin
                        rx <= rx + 1'b1;
                    end
                end
            end
        end
    end

endmodule
